// File: rtl/load_store_unit.sv
// Load/store unit between the core FSM and a word-wide synchronous-read block RAM.
// Loads use a two-cycle read path; sub-word stores do a read-modify-write.
module load_store_unit #(
    parameter int RAM_AWIDTH = 10,
    parameter int MEM_OPW    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [31:0]           mem_addr,
    input  logic [MEM_OPW-1:0]    mem_op,
    input  logic [31:0]           mem_data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           mem_data_out,
    output logic [RAM_AWIDTH-1:0] ram_addr,
    output logic                  ram_wren,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_CAP  = 2'd2,
        S_WR   = 2'd3
    } state_t;

    localparam logic [MEM_OPW-1:0] OP_NONE = MEM_OPW'(4'd0);
    localparam logic [MEM_OPW-1:0] OP_LB   = MEM_OPW'(4'd1);
    localparam logic [MEM_OPW-1:0] OP_LH   = MEM_OPW'(4'd2);
    localparam logic [MEM_OPW-1:0] OP_LW   = MEM_OPW'(4'd3);
    localparam logic [MEM_OPW-1:0] OP_LBU  = MEM_OPW'(4'd4);
    localparam logic [MEM_OPW-1:0] OP_LHU  = MEM_OPW'(4'd5);
    localparam logic [MEM_OPW-1:0] OP_SB   = MEM_OPW'(4'd6);
    localparam logic [MEM_OPW-1:0] OP_SH   = MEM_OPW'(4'd7);
    localparam logic [MEM_OPW-1:0] OP_SW   = MEM_OPW'(4'd8);

    state_t                  state_r, state_nx_s;
    logic [MEM_OPW-1:0]      op_r, op_nx_s;
    logic [1:0]              lane_r, lane_nx_s;
    logic [15:0]             sdata_r, sdata_nx_s;
    logic                    busy_r, busy_nx_s;
    logic                    done_r, done_nx_s;
    logic                    err_r, err_nx_s;
    logic [31:0]             dout_r, dout_nx_s;
    logic [RAM_AWIDTH-1:0]   ram_addr_r, ram_addr_nx_s;
    logic                    ram_wren_r, ram_wren_nx_s;
    logic [31:0]             ram_wdata_r, ram_wdata_nx_s;
    logic                    acc_bad_s;

    // Pick the addressed lane out of a RAM word and extend it as the op asks.
    function automatic logic [31:0] load_extract(input logic [MEM_OPW-1:0] op,
                                                 input logic [1:0] lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   res = {{24{b[7]}}, b};
            OP_LBU:  res = {24'd0, b};
            OP_LH:   res = {{16{h[15]}}, h};
            OP_LHU:  res = {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed byte or half of an old RAM word with store data.
    function automatic logic [31:0] store_merge(input logic [MEM_OPW-1:0] op,
                                                input logic [1:0] lane,
                                                input logic [15:0] sd,
                                                input logic [31:0] word);
        logic [31:0] res;
        res = word;
        if (op == OP_SB) begin
            case (lane)
                2'd0:    res[7:0]   = sd[7:0];
                2'd1:    res[15:8]  = sd[7:0];
                2'd2:    res[23:16] = sd[7:0];
                default: res[31:24] = sd[7:0];
            endcase
        end else if (op == OP_SH) begin
            if (lane[1]) res[31:16] = sd;
            else         res[15:0]  = sd;
        end else begin
            res = word;
        end
        return res;
    endfunction

    // Request rejection checks, in priority order.
    always_comb begin
        acc_bad_s = 1'b0;
        if ((mem_op == OP_NONE) || (mem_op > OP_SW)) begin
            acc_bad_s = 1'b1;
        end else if ((mem_addr >> (RAM_AWIDTH + 2)) != 32'd0) begin
            acc_bad_s = 1'b1;
        end else if (((mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH)) && mem_addr[0]) begin
            acc_bad_s = 1'b1;
        end else if (((mem_op == OP_LW) || (mem_op == OP_SW)) && (mem_addr[1:0] != 2'b00)) begin
            acc_bad_s = 1'b1;
        end else begin
            acc_bad_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req && !acc_bad_s) state_nx_s = (mem_op == OP_SW) ? S_WR : S_RD;
                else                   state_nx_s = S_IDLE;
            end
            S_RD:    state_nx_s = S_CAP;
            S_CAP:   state_nx_s = ((op_r == OP_SB) || (op_r == OP_SH)) ? S_WR : S_IDLE;
            S_WR:    state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and latched request fields.
    always_comb begin
        op_nx_s        = op_r;
        lane_nx_s      = lane_r;
        sdata_nx_s     = sdata_r;
        done_nx_s      = 1'b0;
        err_nx_s       = 1'b0;
        dout_nx_s      = dout_r;
        ram_addr_nx_s  = ram_addr_r;
        ram_wren_nx_s  = 1'b0;
        ram_wdata_nx_s = ram_wdata_r;
        case (state_r)
            S_IDLE: begin
                if (req && acc_bad_s) begin
                    done_nx_s = 1'b1;
                    err_nx_s  = 1'b1;
                end else if (req) begin
                    op_nx_s       = mem_op;
                    lane_nx_s     = mem_addr[1:0];
                    sdata_nx_s    = mem_data_in[15:0];
                    ram_addr_nx_s = mem_addr[RAM_AWIDTH+1:2];
                    if (mem_op == OP_SW) begin
                        ram_wdata_nx_s = mem_data_in;
                        ram_wren_nx_s  = 1'b1;
                    end else begin
                        ram_wren_nx_s  = 1'b0;
                    end
                end else begin
                    done_nx_s = 1'b0;
                end
            end
            S_RD: begin
                done_nx_s = 1'b0;
            end
            S_CAP: begin
                if ((op_r == OP_SB) || (op_r == OP_SH)) begin
                    ram_wdata_nx_s = store_merge(op_r, lane_r, sdata_r, ram_rdata);
                    ram_wren_nx_s  = 1'b1;
                end else begin
                    dout_nx_s = load_extract(op_r, lane_r, ram_rdata);
                    done_nx_s = 1'b1;
                end
            end
            S_WR: begin
                done_nx_s = 1'b1;
            end
            default: begin
                done_nx_s = 1'b0;
            end
        endcase
        busy_nx_s = (state_nx_s != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            op_r        <= OP_NONE;
            lane_r      <= 2'd0;
            sdata_r     <= 16'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            dout_r      <= 32'd0;
            ram_addr_r  <= '0;
            ram_wren_r  <= 1'b0;
            ram_wdata_r <= 32'd0;
        end else begin
            state_r     <= state_nx_s;
            op_r        <= op_nx_s;
            lane_r      <= lane_nx_s;
            sdata_r     <= sdata_nx_s;
            busy_r      <= busy_nx_s;
            done_r      <= done_nx_s;
            err_r       <= err_nx_s;
            dout_r      <= dout_nx_s;
            ram_addr_r  <= ram_addr_nx_s;
            ram_wren_r  <= ram_wren_nx_s;
            ram_wdata_r <= ram_wdata_nx_s;
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign err          = err_r;
    assign mem_data_out = dout_r;
    assign ram_addr     = ram_addr_r;
    assign ram_wren     = ram_wren_r;
    assign ram_wdata    = ram_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array memory model predicts every
// completion and RAM write; a monitor compares them as the DUT presents them.
module tb_load_store_unit;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst, req;
    logic [31:0]   mem_addr, mem_data_in;
    logic [7:0]    mem_op;
    logic          busy, done, err;
    logic [31:0]   mem_data_out;
    logic [AW-1:0] ram_addr;
    logic          ram_wren;
    logic [31:0]   ram_wdata, ram_rdata;

    logic          pre_we;
    logic [AW-1:0] pre_a;
    logic [31:0]   pre_d;

    load_store_unit #(.RAM_AWIDTH(AW), .MEM_OPW(8)) dut (
        .clk(clk), .rst(rst), .req(req), .mem_addr(mem_addr), .mem_op(mem_op),
        .mem_data_in(mem_data_in), .busy(busy), .done(done), .err(err),
        .mem_data_out(mem_data_out), .ram_addr(ram_addr), .ram_wren(ram_wren),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM with a bench preload port.
    logic [31:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (pre_we) ram[pre_a] <= pre_d;
        else if (ram_wren) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit e; logic [31:0] data; int lat; int acc; } exp_t;
    typedef struct { logic [AW-1:0] a; logic [31:0] d; } wr_t;
    exp_t exp_q[$];
    wr_t  wr_q[$];
    int   done_cycles[$];

    byte unsigned mdl [0:4095];
    logic [31:0]  last_load = 32'd0;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [31:0] mdl_word(input int idx);
        return {mdl[4*idx+3], mdl[4*idx+2], mdl[4*idx+1], mdl[4*idx]};
    endfunction

    // Reference: decide outcome from op/address rules and update the byte model.
    task automatic model_issue(input int op, input logic [31:0] addr, input logic [31:0] data, input int acc);
        exp_t   x;
        wr_t    w;
        longint v;
        int     a;
        bit     ok;
        ok = (op >= 1) && (op <= 8) && (addr < 32'd4096);
        if (ok && (op == 2 || op == 5 || op == 7) && (addr % 2 != 0)) ok = 1'b0;
        if (ok && (op == 3 || op == 8) && (addr % 4 != 0)) ok = 1'b0;
        a = int'(addr[11:0]);
        x.acc = acc;
        x.e   = !ok;
        x.lat = 1;
        if (ok) begin
            case (op)
                1: begin v = mdl[a]; if (v > 127) v -= 256; last_load = 32'(v); x.lat = 3; end
                4: begin v = mdl[a]; last_load = 32'(v); x.lat = 3; end
                2: begin v = mdl[a] + 256 * mdl[a+1]; if (v > 32767) v -= 65536; last_load = 32'(v); x.lat = 3; end
                5: begin v = mdl[a] + 256 * mdl[a+1]; last_load = 32'(v); x.lat = 3; end
                3: begin last_load = mdl_word(a / 4); x.lat = 3; end
                6: begin mdl[a] = data[7:0]; x.lat = 4; end
                7: begin mdl[a] = data[7:0]; mdl[a+1] = data[15:8]; x.lat = 4; end
                default: begin
                    mdl[a] = data[7:0]; mdl[a+1] = data[15:8];
                    mdl[a+2] = data[23:16]; mdl[a+3] = data[31:24]; x.lat = 2;
                end
            endcase
            if (op >= 6) begin
                w.a = AW'(a / 4);
                w.d = mdl_word(a / 4);
                wr_q.push_back(w);
            end
        end
        x.data = last_load;
        exp_q.push_back(x);
    endtask

    // Monitor: every done and every RAM write must match the head of its queue.
    always @(negedge clk) begin : monitor
        exp_t x;
        wr_t  w;
        if (err === 1'b1 && done !== 1'b1) chk("err_without_done", {31'd0, done}, 32'd1);
        if (done === 1'b1) begin
            done_cycles.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done=1 err=%0b expected no completion (cycle %0d)", err, cyc);
            end else begin
                x = exp_q.pop_front();
                chk("err", {31'd0, err}, {31'd0, x.e});
                chk("mem_data_out", mem_data_out, x.data);
                chk("latency", 32'(cyc - x.acc), 32'(x.lat));
            end
        end
        if (ram_wren === 1'b1) begin
            if (wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write: got write %08h to %0d expected none (cycle %0d)", ram_wdata, ram_addr, cyc);
            end else begin
                w = wr_q.pop_front();
                chk("wr_addr", 32'(ram_addr), 32'(w.a));
                chk("wr_data", ram_wdata, w.d);
            end
        end
    end

    // mode: 0 drop req while busy, 1 hold req with previous fields, 2 drive random requests while busy.
    task automatic issue(input int op, input logic [31:0] addr, input logic [31:0] data, input bit track, input int mode);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            if (mode == 2) begin
                req = 1'b1;
                mem_op = 8'($urandom_range(1, 8));
                mem_addr = 32'($urandom_range(0, 1023)) << 2;
                mem_data_in = $urandom;
            end else if (mode == 0) begin
                req = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        if (busy) begin
            chk("issue_timeout_busy", {31'd0, busy}, 32'd0);
            req = 1'b0;
        end else begin
            req = 1'b1;
            mem_op = 8'(op);
            mem_addr = addr;
            mem_data_in = data;
            if (track) model_issue(op, addr, data, cyc);
            @(posedge clk);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        req = 1'b0;
        while ((exp_q.size() != 0 || wr_q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout_pending", 32'(exp_q.size() + wr_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [31:0] d_addr [9] = '{32'h44, 32'h45, 32'h47, 32'h46, 32'h44, 32'h46, 32'h44, 32'h44, 32'h44};
    int          d_op   [9] = '{3, 1, 4, 2, 5, 6, 7, 8, 3};
    logic [31:0] d_data [9] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h123456CC, 32'h00001234, 32'hDEADBEEF, 32'd0};
    logic [31:0] d_out  [9] = '{32'h8899AABB, 32'hFFFFFFAA, 32'h00000088, 32'hFFFF8899, 32'h0000AABB,
                                32'h0000AABB, 32'h0000AABB, 32'h0000AABB, 32'hDEADBEEF};
    logic [31:0] d_ram  [9] = '{32'h8899AABB, 32'h8899AABB, 32'h8899AABB, 32'h8899AABB, 32'h8899AABB,
                                32'h88CCAABB, 32'h88CC1234, 32'hDEADBEEF, 32'hDEADBEEF};
    int          e_op   [4] = '{3, 7, 9, 3};
    logic [31:0] e_addr [4] = '{32'h42, 32'h43, 32'h44, 32'h00001000};

    initial begin
        logic [31:0] w;
        rst = 1'b1; req = 1'b0; mem_op = 8'd0; mem_addr = 32'd0; mem_data_in = 32'd0;
        pre_we = 1'b0; pre_a = '0; pre_d = 32'd0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            w = (i == 17) ? 32'h8899AABB : $urandom;
            pre_we = 1'b1; pre_a = AW'(i); pre_d = w;
            {mdl[4*i+3], mdl[4*i+2], mdl[4*i+1], mdl[4*i]} = w;
        end
        @(negedge clk);
        pre_we = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_wren", {31'd0, ram_wren}, 32'd0);
        chk("rst_dout", mem_data_out, 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            issue(d_op[i], d_addr[i], d_data[i], 1'b1, 0);
            drain();
            chk("dir_dout", mem_data_out, d_out[i]);
            chk("dir_ram17", ram[17], d_ram[i]);
        end

        for (int i = 0; i < 4; i++) begin
            issue(e_op[i], e_addr[i], 32'hFFFFFFFF, 1'b1, 0);
            drain();
            chk("err_dout_held", mem_data_out, 32'hDEADBEEF);
            chk("err_ram17", ram[17], 32'hDEADBEEF);
        end

        done_cycles.delete();
        issue(3, 32'h0, 32'd0, 1'b1, 0);
        issue(3, 32'h4, 32'd0, 1'b1, 1);
        issue(3, 32'h8, 32'd0, 1'b1, 1);
        drain();
        chk("b2b_count", 32'(done_cycles.size()), 32'd3);
        if (done_cycles.size() == 3) begin
            chk("b2b_gap1", 32'(done_cycles[1] - done_cycles[0]), 32'd3);
            chk("b2b_gap2", 32'(done_cycles[2] - done_cycles[1]), 32'd3);
        end

        issue(6, 32'h46, 32'h123456CC, 1'b0, 0);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_wren", {31'd0, ram_wren}, 32'd0);
        last_load = 32'd0;
        repeat (3) @(negedge clk);
        issue(3, 32'h44, 32'd0, 1'b1, 0);
        drain();
        chk("midrst_reload", mem_data_out, 32'hDEADBEEF);

        for (int t = 0; t < 200; t++) begin
            int op;
            logic [31:0] addr;
            op = $urandom_range(0, 10);
            addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 71));
            issue(op, addr, $urandom, 1'b1, ($urandom_range(0, 1) == 1) ? 2 : 0);
        end
        drain();

        for (int i = 0; i < 32; i++) chk("final_ram", ram[i], mdl_word(i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
